// File: rtl/ysyx_22050550_shift_divider.sv
// Radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W forms, one quotient bit per cycle.
// Optional: define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module ysyx_22050550_shift_divider #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_Exu_DivValid,
  input  logic            io_Exu_Flush,
  input  logic            io_Exu_Divw,
  input  logic [1:0]      io_Exu_DivSigned,
  input  logic [XLEN-1:0] io_Exu_Divdend,
  input  logic [XLEN-1:0] io_Exu_Divisor,
  output logic            io_Exu_DivReady,
  output logic            io_Exu_OutValid,
  output logic [XLEN-1:0] io_Exu_Quotient,
  output logic [XLEN-1:0] io_Exu_Remainder
);
  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_reg, state_next;

  logic [CW-1:0]   counter_reg;
  logic [XLEN-1:0] work_reg;      // dividend bits shift out of the top, quotient bits in at the bottom
  logic [XLEN-1:0] partial_reg;
  logic [XLEN-1:0] divisor_reg;
  logic            qneg_reg, rneg_reg, divw_reg;
  logic [XLEN-1:0] quotient_reg, remainder_reg;

  function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] v, input logic w);
    return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
  endfunction

  // Operand preparation for the accept edge
  logic            sd, sv, a_sign, b_sign;
  logic [XLEN-1:0] eff_dividend, eff_divisor, abs_dividend, abs_divisor;
  logic            accept, div_zero, overflow, early_out, special;
  logic [XLEN-1:0] special_q, special_r;

  assign sd = io_Exu_DivSigned[1];
  assign sv = io_Exu_DivSigned[0];

  always_comb begin
    eff_dividend = io_Exu_Divdend;
    eff_divisor  = io_Exu_Divisor;
    if (io_Exu_Divw) begin
      eff_dividend = {{HALF{sd & io_Exu_Divdend[HALF-1]}}, io_Exu_Divdend[HALF-1:0]};
      eff_divisor  = {{HALF{sv & io_Exu_Divisor[HALF-1]}}, io_Exu_Divisor[HALF-1:0]};
    end
  end

  assign a_sign       = sd & eff_dividend[XLEN-1];
  assign b_sign       = sv & eff_divisor[XLEN-1];
  assign abs_dividend = a_sign ? -eff_dividend : eff_dividend;
  assign abs_divisor  = b_sign ? -eff_divisor : eff_divisor;
  assign div_zero     = (eff_divisor == '0);
  assign overflow     = sd & sv & (eff_divisor == '1) &
                        (io_Exu_Divw ? (eff_dividend == {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}})
                                     : (eff_dividend == {1'b1, {(XLEN-1){1'b0}}}));
`ifdef DIV_EARLY_OUT_EN
  assign early_out    = !div_zero && (abs_dividend < abs_divisor);
`else
  assign early_out    = 1'b0;
`endif
  assign special      = div_zero | overflow | early_out;
  assign accept       = (state_reg == IDLE) && io_Exu_DivValid && !io_Exu_Flush;

  always_comb begin
    special_q = '0;
    special_r = fit(eff_dividend, io_Exu_Divw);
    if (div_zero) begin
      special_q = '1;
    end else if (overflow) begin
      special_q = fit(eff_dividend, io_Exu_Divw);
      special_r = '0;
    end
  end

  // One restoring iteration
  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] partial_step, work_step, q_signed, r_signed;

  assign shifted      = {partial_reg, work_reg[XLEN-1]};
  assign fits         = shifted >= {1'b0, divisor_reg};
  assign partial_step = fits ? (shifted[XLEN-1:0] - divisor_reg) : shifted[XLEN-1:0];
  assign work_step    = {work_reg[XLEN-2:0], fits};
  assign q_signed     = qneg_reg ? -work_step : work_step;
  assign r_signed     = rneg_reg ? -partial_step : partial_step;

  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next      = state_reg;
    io_Exu_DivReady = 1'b0;
    io_Exu_OutValid = 1'b0;
    case (state_reg)
      IDLE: begin
        io_Exu_DivReady = 1'b1;
        if (io_Exu_DivValid && !io_Exu_Flush) state_next = special ? DONE : RUN;
      end
      RUN: begin
        if (io_Exu_Flush)            state_next = IDLE;
        else if (counter_reg == 1)   state_next = DONE;
      end
      DONE: begin
        io_Exu_OutValid = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      counter_reg   <= '0;
      work_reg      <= '0;
      partial_reg   <= '0;
      divisor_reg   <= '0;
      qneg_reg      <= 1'b0;
      rneg_reg      <= 1'b0;
      divw_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else if (accept) begin
      counter_reg <= io_Exu_Divw ? CW'(HALF) : CW'(XLEN);
      // W operands are left-aligned so the first bit shifted out is bit 31
      work_reg    <= io_Exu_Divw ? {abs_dividend[HALF-1:0], {HALF{1'b0}}} : abs_dividend;
      partial_reg <= '0;
      divisor_reg <= abs_divisor;
      qneg_reg    <= sd & sv & (a_sign ^ b_sign);
      rneg_reg    <= a_sign;
      divw_reg    <= io_Exu_Divw;
      if (special) begin
        quotient_reg  <= special_q;
        remainder_reg <= special_r;
      end
    end else if (state_reg == RUN && !io_Exu_Flush) begin
      counter_reg <= counter_reg - 1'b1;
      work_reg    <= work_step;
      partial_reg <= partial_step;
      if (counter_reg == 1) begin
        quotient_reg  <= fit(q_signed, divw_reg);
        remainder_reg <= fit(r_signed, divw_reg);
      end
    end
  end

  assign io_Exu_Quotient  = quotient_reg;
  assign io_Exu_Remainder = remainder_reg;
endmodule

// File: tb/tb_ysyx_22050550_shift_divider.sv
// Directed bench for the shift divider: results, latency, handshake, flush and reset.
module tb_ysyx_22050550_shift_divider;
  logic        clock;
  logic        reset;
  logic        div_valid, flush, divw;
  logic [1:0]  div_signed;
  logic [63:0] dividend, divisor;
  logic        div_ready, out_valid;
  logic [63:0] quotient, remainder;

  int check_count = 0;
  int pass_count  = 0;

  ysyx_22050550_shift_divider #(.XLEN(64)) dut (
    .clock            (clock),
    .reset            (reset),
    .io_Exu_DivValid  (div_valid),
    .io_Exu_Flush     (flush),
    .io_Exu_Divw      (divw),
    .io_Exu_DivSigned (div_signed),
    .io_Exu_Divdend   (dividend),
    .io_Exu_Divisor   (divisor),
    .io_Exu_DivReady  (div_ready),
    .io_Exu_OutValid  (out_valid),
    .io_Exu_Quotient  (quotient),
    .io_Exu_Remainder (remainder)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one request, scramble inputs after acceptance, and check result and timing.
  // exp_k is the number of edges after the accept edge before OutValid is seen.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] sgn, input logic w, input int exp_k,
                       input logic [63:0] eq, input logic [63:0] er);
    int k;
    logic ready_bad;
    @(negedge clock);
    div_valid = 1'b1; dividend = a; divisor = b; div_signed = sgn; divw = w;
    @(posedge clock); #1;
    dividend = ~a; divisor = b ^ 64'h5A5A_5A5A_5A5A_5A5A; div_signed = ~sgn; divw = ~w;
    k = 0;
    ready_bad = 1'b0;
    while (!out_valid && k < 100) begin
      if (div_ready) ready_bad = 1'b1;
      @(posedge clock); #1;
      k++;
    end
    check({tag, "_lat"}, 64'(k), 64'(exp_k));
    check({tag, "_ready_low"}, {63'b0, ready_bad | div_ready}, 64'd0);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    $display("op %s: q=%h r=%h latency=%0d", tag, quotient, remainder, k);
    div_valid = 1'b0;
    @(posedge clock); #1;
    check({tag, "_pulse"}, {63'b0, out_valid}, 64'd0);
    check({tag, "_ready_back"}, {63'b0, div_ready}, 64'd1);
  endtask

  initial begin
    int seen;
    reset = 1'b1; div_valid = 1'b0; flush = 1'b0; divw = 1'b0;
    div_signed = 2'b00; dividend = '0; divisor = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", {63'b0, div_ready}, 64'd1);
    check("rst_valid", {63'b0, out_valid}, 64'd0);
    check("rst_q", quotient, 64'd0);
    check("rst_r", remainder, 64'd0);
    reset = 1'b0;

    do_op("udiv",     64'd100, 64'd7, 2'b00, 1'b0, 64, 64'd14, 64'd2);
    do_op("sdiv",     64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2'b11, 1'b0, 64,
          64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op("sdiv_nb",  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 2'b11, 1'b0, 64,
          64'hFFFF_FFFF_FFFF_FFFD, 64'd1);
    do_op("udiv_big", 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 2'b00, 1'b0, 64,
          64'h0FFF_FFFF_FFFF_FFFF, 64'hF);
    do_op("divzero",  64'h1234, 64'd0, 2'b00, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234);
    do_op("ovf",      64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, 0,
          64'h8000_0000_0000_0000, 64'd0);
    do_op("divw_s",   64'h0000_0001_8000_0000, 64'd2, 2'b11, 1'b1, 32,
          64'hFFFF_FFFF_C000_0000, 64'd0);
    do_op("divw_u",   64'hDEAD_0000_0000_0064, 64'h1234_5678_0000_0007, 2'b00, 1'b1, 32,
          64'd14, 64'd2);
    do_op("divw_zero", 64'd5, 64'hABCD_0000_0000_0000, 2'b11, 1'b1, 0,
          64'hFFFF_FFFF_FFFF_FFFF, 64'd5);
    do_op("sdiv_prev", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2'b11, 1'b0, 64,
          64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);

    // Flush at cycle 10 of a 64-bit operation
    @(negedge clock);
    div_valid = 1'b1; dividend = 64'h1000; divisor = 64'd3; div_signed = 2'b00; divw = 1'b0;
    @(posedge clock); #1;
    repeat (9) @(posedge clock);
    #1;
    flush = 1'b1; div_valid = 1'b0;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_ready", {63'b0, div_ready}, 64'd1);
    check("flush_q", quotient, 64'hFFFF_FFFF_FFFF_FFFD);
    check("flush_r", remainder, 64'hFFFF_FFFF_FFFF_FFFF);
    seen = 0;
    repeat (70) begin
      @(posedge clock); #1;
      if (out_valid) seen++;
    end
    check("flush_no_valid", 64'(seen), 64'd0);
    $display("op flush: q=%h r=%h stray_valid=%0d", quotient, remainder, seen);
    do_op("after_flush", 64'd100, 64'd7, 2'b00, 1'b0, 64, 64'd14, 64'd2);

    // Flush held in IDLE blocks acceptance
    @(negedge clock);
    div_valid = 1'b1; flush = 1'b1; dividend = 64'd9; divisor = 64'd0;
    seen = 0;
    repeat (3) begin
      @(posedge clock); #1;
      if (!div_ready || out_valid) seen++;
    end
    div_valid = 1'b0; flush = 1'b0;
    check("idle_flush_block", 64'(seen), 64'd0);
    $display("op idle_flush: blocked_cycles_bad=%0d", seen);

    // Reset in the middle of an operation
    @(negedge clock);
    div_valid = 1'b1; dividend = 64'd50; divisor = 64'd3; div_signed = 2'b00; divw = 1'b0;
    @(posedge clock); #1;
    div_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midrst_ready", {63'b0, div_ready}, 64'd1);
    check("midrst_valid", {63'b0, out_valid}, 64'd0);
    check("midrst_q", quotient, 64'd0);
    check("midrst_r", remainder, 64'd0);
    $display("op midreset: q=%h r=%h ready=%0d", quotient, remainder, div_ready);
    do_op("after_rst", 64'd100, 64'd7, 2'b00, 1'b0, 64, 64'd14, 64'd2);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule

// File: doc/ysyx_22050550_shift_divider.md
Name: ysyx_22050550_shift_divider

Overview:
Multi-cycle radix-2 restoring integer divider. It is the responder side of the EXU divide handshake (DivValid/DivReady/OutValid). It covers RV64M DIV/DIVU/REM/REMU and their W forms, producing one quotient bit per cycle. The EXU holds its request until OutValid, then captures Quotient/Remainder.

Parameters:
XLEN, 64, operand/result width; W forms operate on XLEN/2 bits.

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
io_Exu_DivValid  in  1  request valid; EXU keeps it high until OutValid
io_Exu_Flush  in  1  abort any in-flight operation
io_Exu_Divw  in  1  32-bit op, results sign-extended to XLEN
io_Exu_DivSigned  in  2  [1]=dividend signed, [0]=divisor signed (EXU drives 11 or 00)
io_Exu_Divdend  in  XLEN  dividend
io_Exu_Divisor  in  XLEN  divisor
io_Exu_DivReady  out  1  high only in IDLE
io_Exu_OutValid  out  1  one-cycle pulse, results valid
io_Exu_Quotient  out  XLEN  quotient
io_Exu_Remainder  out  XLEN  remainder

Behaviour:
- Reset values: DivReady=1, OutValid=0, Quotient=0, Remainder=0, state=IDLE, counter=0.
- States: IDLE, RUN, DONE.
- Accept: at edge E0 with state==IDLE && DivValid && !Flush. Operands, Divw and DivSigned are latched at E0; later changes to the inputs are ignored.
- Operand prep at E0:
  - If Divw, use bits [31:0] and sign/zero-extend per DivSigned.
  - Take absolute values of the signed operands.
  - Record qneg = sd&sv&(a_sign^b_sign) and rneg = sd&a_sign, where sd/sv are the signed bits.
- N = XLEN/2 if Divw, else XLEN.
- Normal path:
  - IDLE -> RUN at E0 with counter=N.
  - Each edge in RUN: shift the partial remainder left by 1 and bring in the next dividend bit (MSB first). If partial >= |divisor|, subtract and set the quotient bit to 1; otherwise set it to 0. Decrement counter.
  - At the edge where counter goes 1->0 (edge E_N), apply sign correction (negate quotient if qneg, remainder if rneg), sign-extend bit 31 if Divw, write the output registers, and go RUN -> DONE.
- DONE: OutValid=1 for exactly one cycle (the cycle after E_N); unconditional DONE -> IDLE at the next edge.
- Latency: 64-bit op gives OutValid in cycle E64..E65; Divw gives E32..E33.
- DivReady=0 from E0 until DONE exits, so it is high again in the cycle after OutValid.
- Quotient/Remainder hold their last value until the next completion. They are not cleared on accept or flush.
- Special cases resolve at E0, IDLE -> DONE directly, so OutValid appears in the cycle after E0:
  - Divisor (effective, post-Divw) == 0: quotient = all ones (sign-extended if Divw), remainder = effective dividend.
  - Signed overflow (dividend = most-negative, divisor = -1, both signed): quotient = effective dividend, remainder = 0.
- Flush:
  - In RUN: next state IDLE, no OutValid, outputs unchanged.
  - In DONE: OutValid still asserts this cycle (already committed); state goes to IDLE.
  - In IDLE with DivValid: request is not accepted.
- Reset mid-operation: immediate return to reset values at that edge.
- A DivValid that stays high after OutValid is treated as a new request in IDLE. Deasserting it is the EXU's responsibility.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined: at E0, if |dividend| < |divisor| (non-zero divisor), go directly to DONE with quotient 0 and remainder = effective signed dividend. Latency is 1 cycle.
- Undefined: such operations take the full N iterations and give identical results.

Test Plan:
- Unsigned 64-bit, dividend 100, divisor 7, Signed=00 -> Quotient=14, Remainder=2; OutValid single pulse 65 cycles after accept edge; DivReady low throughout, high the cycle after.
- Signed: dividend 0xFFFFFFFFFFFFFFF9 (-7), divisor 2, Signed=11 -> Quotient=0xFFFFFFFFFFFFFFFD, Remainder=0xFFFFFFFFFFFFFFFF.
- Divide by zero: dividend 0x1234, divisor 0 -> Quotient=0xFFFFFFFFFFFFFFFF, Remainder=0x1234; OutValid the cycle after accept.
- Overflow: 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF, Signed=11 -> Quotient=0x8000000000000000, Remainder=0, 1-cycle latency.
- Divw signed: dividend 0x0000000180000000, divisor 2 -> Quotient=0xFFFFFFFFC0000000, Remainder=0; OutValid 33 cycles after accept.
- Flush at cycle 10 of a 64-bit op -> no OutValid, DivReady high next cycle, Quotient/Remainder retain previous results; a following 100/7 request completes correctly.
